event_pulse_queue: RTL
======================

EVENT_PULSE_QUEUE -- requirements
Module: event_pulse_queue

Interface
REQ-001 Parameter CNT_W, default 4, width of the pending-event counter; maximum pending events = 2^CNT_W-1.
REQ-002 Parameter HS_TMO, default 3, number of cycles allowed in WAIT_HI for sync_busy to rise.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 ev_in  input  1  source event; each cycle high counts as one event.
REQ-006 sync_busy  input  1  busy flag from the downstream handshake pulse synchronizer, same clock domain.
REQ-007 ovf_clr  input  1  clears overflow when high.
REQ-008 err_clr  input  1  clears hs_err when high.
REQ-009 sync_req  output  1  one-cycle request pulse to the synchronizer data input; registered.
REQ-010 pending  output  CNT_W  count of queued events not yet issued; registered.
REQ-011 overflow  output  1  sticky flag: an event was dropped.
REQ-012 hs_err  output  1  sticky flag: sync_busy failed to rise after a request.

Function
REQ-013 The FSM SHALL have the states IDLE, SEND, WAIT_HI and WAIT_LO.
REQ-014 sync_req SHALL be high exactly during cycles in which the state is SEND, and SHALL never be high for two consecutive cycles.
REQ-015 Transitions SHALL be as follows:
- IDLE->SEND when pending!=0 and sync_busy==0; else stay in IDLE.
- SEND->WAIT_HI, unconditionally.
- WAIT_HI->WAIT_LO when sync_busy==1.
- WAIT_HI->WAIT_LO with hs_err set when sync_busy has stayed 0 for HS_TMO cycles in WAIT_HI.
- WAIT_LO->IDLE when sync_busy==0.
REQ-016 The timeout counter SHALL clear on entry to WAIT_HI, increment on each WAIT_HI cycle, and be ignored in other states.
REQ-017 pending SHALL change in the cycle after the event:
- +1 for each ev_in cycle.
- -1 for each SEND cycle.
- Unchanged when ev_in and SEND coincide.
REQ-018 With pending==2^CNT_W-1 and ev_in high without a coinciding SEND, the event SHALL be dropped, pending SHALL hold, and overflow SHALL be set next cycle.
REQ-019 pending SHALL never wrap; underflow is impossible because SEND requires pending!=0.
REQ-020 overflow SHALL remain set until ovf_clr; a simultaneous set and ovf_clr SHALL leave overflow set.
REQ-021 hs_err SHALL remain set until err_clr; a simultaneous set and err_clr SHALL leave hs_err set.
REQ-022 Minimum spacing between sync_req pulses SHALL be 4 cycles (SEND, WAIT_HI≥1, WAIT_LO≥1, IDLE).
REQ-023 Latency from ev_in to sync_req SHALL be 2 cycles when the queue is empty, the FSM is in IDLE and sync_busy==0.
REQ-024 sync_busy high while in IDLE SHALL block issue; pending SHALL still accumulate.

Reset
REQ-025 While reset is high, the state SHALL be IDLE, and sync_req=0, pending=0, overflow=0, hs_err=0, with the timeout counter cleared.
REQ-026 reset asserted mid-handshake (any state) SHALL discard all pending events with no further sync_req, and reset SHALL override ev_in, ovf_clr and err_clr.
REQ-027 After reset deasserts, the block SHALL issue nothing until a new ev_in arrives.

Verification
REQ-028 Single event: ev_in pulse at cycle 0, sync_busy mirrors a model synchronizer (rises 1 cycle after sync_req, falls 6 cycles later) -> sync_req high at cycle 2 only; pending 1 at cycle 1, 0 at cycle 3.
REQ-029 Burst: ev_in high 5 consecutive cycles -> pending peaks at 4 or 5, exactly 5 sync_req pulses, each issued only after sync_busy returns 0, final pending=0.
REQ-030 Overflow: CNT_W=4, sync_busy held 1, ev_in high 17 cycles -> pending saturates at 15, overflow=1; ovf_clr pulse -> overflow=0; ovf_clr coinciding with a further drop -> overflow stays 1.
REQ-031 Timeout: sync_busy tied 0, one ev_in -> one sync_req, hs_err=1 after HS_TMO WAIT_HI cycles, FSM returns to IDLE; err_clr -> hs_err=0.
REQ-032 Simultaneous: ev_in high in the SEND cycle with pending=1 -> pending stays 1 and a second sync_req follows after the handshake completes.
REQ-033 Reset mid-operation: pending=3, state WAIT_LO, reset high 1 cycle -> pending=0, sync_req=0, flags 0, no sync_req afterwards without a new ev_in.

Source files
------------

// File: rtl/event_pulse_queue.sv
// event_pulse_queue: counts source events and issues them one at a time as
// single-cycle requests to a handshake pulse synchronizer, waiting for busy.
//
// Ports:
//   clk        - clock, all state changes on its rising edge
//   reset      - synchronous active-high reset
//   ev_in      - source event, one event per high cycle
//   sync_busy  - busy flag from the downstream pulse synchronizer
//   ovf_clr    - clears the overflow flag
//   err_clr    - clears the handshake error flag
//   sync_req   - registered one-cycle request pulse (high in SEND)
//   pending    - registered count of queued, not yet issued events
//   overflow   - sticky: an event was dropped on a full queue
//   hs_err     - sticky: sync_busy never rose after a request
module event_pulse_queue #(
    parameter int CNT_W  = 4,
    parameter int HS_TMO = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ev_in,
    input  logic             sync_busy,
    input  logic             ovf_clr,
    input  logic             err_clr,
    output logic             sync_req,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             hs_err
);

    localparam int TMO_W =
        (HS_TMO > 1) ? $clog2(HS_TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'(HS_TMO - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_req;
    logic [CNT_W-1:0] r_pending;
    logic [TMO_W-1:0] r_tmo;
    logic             r_ovf;
    logic             r_err;

    logic w_send;
    logic w_full;
    logic w_inc;
    logic w_dec;
    logic w_drop;
    logic w_tmo_hit;

    assign w_send = (r_state == SEND);
    assign w_full = (r_pending == CNT_MAX);

    // An event and a send in the same cycle cancel out.
    assign w_inc  = ev_in && !w_send && !w_full;
    assign w_dec  = w_send && !ev_in;
    assign w_drop = ev_in && !w_send && w_full;

    always_comb begin
        w_next    = r_state;
        w_tmo_hit = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_pending != '0 && !sync_busy)
                    w_next = SEND;
            end
            SEND: begin
                w_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (sync_busy) begin
                    w_next = WAIT_LO;
                end else if (r_tmo == TMO_LAST) begin
                    // Busy never came; give up and
                    // still wait for a clean low.
                    w_next    = WAIT_LO;
                    w_tmo_hit = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!sync_busy)
                    w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_pending <= '0;
            r_tmo     <= '0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            // Registered copy of "state is SEND".
            r_req   <= (w_next == SEND);

            if (w_inc)
                r_pending <= r_pending + CNT_ONE;
            else if (w_dec)
                r_pending <= r_pending - CNT_ONE;

            // Held at zero outside WAIT_HI, so it
            // starts from zero on every entry.
            if (r_state == WAIT_HI)
                r_tmo <= r_tmo + TMO_ONE;
            else
                r_tmo <= '0;

            if (w_drop)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;

            if (w_tmo_hit)
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;
        end
    end

    assign sync_req = r_req;
    assign pending  = r_pending;
    assign overflow = r_ovf;
    assign hs_err   = r_err;

endmodule
